// File: rtl/pc_ifid_stage.sv
// Fetch-stage PC control and IF/ID pipeline register.
// Picks the next PC from the sequential, branch or jump path, and supports stall, flush and halt.
module pc_ifid_stage #(
  parameter int unsigned    LEN      = 32,
  parameter logic [LEN-1:0] PC_RESET = '0,
  parameter logic [5:0]     HALT_OPC = 6'b111111
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic           i_stall,
  input  logic           i_flush,
  input  logic [LEN-1:0] i_pc_plus4,
  input  logic           i_branch_taken,
  input  logic [LEN-1:0] i_branch_target,
  input  logic           i_jump,
  input  logic [LEN-1:0] i_jump_target,
  input  logic [31:0]    i_instr,
  output logic [LEN-1:0] o_pc,
  output logic           o_adder_enable,
  output logic [LEN-1:0] o_ifid_pc4,
  output logic [31:0]    o_ifid_instr,
  output logic           o_ifid_valid,
  output logic           o_halted
);

  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0]    ifid_instr_q, ifid_instr_d;
  logic           ifid_valid_q, ifid_valid_d;
  logic           halted_q, halted_d;

  logic redirect;
  logic adv;
  logic fetch_is_halt;

  assign redirect      = i_branch_taken | i_jump;
  assign adv           = i_enable & ~i_stall & ~halted_q & ~redirect;
  assign fetch_is_halt = (i_instr[31:26] == HALT_OPC);

  // Priority: redirect > flush > stall > halted > normal advance.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;

    if (i_enable) begin
      if (redirect) begin
        // Branch wins because it belongs to the older instruction.
        pc_d         = i_branch_taken ? i_branch_target : i_jump_target;
        ifid_pc4_d   = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
        halted_d     = 1'b0;
      end else if (i_flush) begin
        ifid_pc4_d   = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
        if (!i_stall && !halted_q) begin
          pc_d = i_pc_plus4;
        end
      end else if (i_stall) begin
        pc_d = pc_q;
      end else if (halted_q) begin
        // Drain a single bubble behind the HALT word.
        ifid_pc4_d   = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_pc4_d   = i_pc_plus4;
        ifid_instr_d = i_instr;
        ifid_valid_d = 1'b1;
        if (fetch_is_halt) begin
          halted_d = 1'b1;
        end else begin
          pc_d = i_pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q         <= PC_RESET;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign o_pc           = pc_q;
  assign o_adder_enable = adv;
  assign o_ifid_pc4     = ifid_pc4_q;
  assign o_ifid_instr   = ifid_instr_q;
  assign o_ifid_valid   = ifid_valid_q;
  assign o_halted       = halted_q;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Bench for pc_ifid_stage: directed scenarios plus a randomized run against a reference model.
module tb_pc_ifid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_plus4, instr, pc, ifid_pc4, ifid_instr;
  logic        adder_enable, ifid_valid, halted;

  logic [31:0] mem [64];
  int tests_run = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Fetch adder and instruction memory; addresses past 0xFF read a synthetic addi-like word.
  assign pc_plus4 = adder_enable ? pc + 32'd4 : pc;
  assign instr    = (pc < 32'd256) ? mem[pc[7:2]] : {6'h08, pc[25:0]};

  pc_ifid_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_pc_plus4     (pc_plus4),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
    .i_jump         (jump),
    .i_jump_target  (jump_target),
    .i_instr        (instr),
    .o_pc           (pc),
    .o_adder_enable (adder_enable),
    .o_ifid_pc4     (ifid_pc4),
    .o_ifid_instr   (ifid_instr),
    .o_ifid_valid   (ifid_valid),
    .o_halted       (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:2]] : {6'h08, a[25:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    jump = 1'b1;
    jump_target = a;
    tick();
    jump = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
    #12;
    tests_run++; if (pc !== 32'h0) begin failed++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    tests_run++; if (ifid_pc4 !== 32'h0) begin failed++;
      $display("FAIL rst_pc4: got %h want %h", ifid_pc4, 32'h0); end
    tests_run++; if (ifid_instr !== 32'h0) begin failed++;
      $display("FAIL rst_instr: got %h want %h", ifid_instr, 32'h0); end
    tests_run++; if (ifid_valid !== 1'b0) begin failed++;
      $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL rst_halted: got %b want 0", halted); end
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_sequential();
    #1;
    tests_run++; if (adder_enable !== 1'b1) begin failed++;
      $display("FAIL seq_adder_en: got %b want 1", adder_enable); end
    tick();
    tests_run++; if (pc !== 32'h4) begin failed++; $display("FAIL seq_pc1: got %h want %h", pc, 32'h4); end
    tests_run++; if (ifid_instr !== 32'h20010005) begin failed++;
      $display("FAIL seq_instr1: got %h want %h", ifid_instr, 32'h20010005); end
    tests_run++; if (ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin failed++;
      $display("FAIL seq_pc4_1: got %h/%b want 4/1", ifid_pc4, ifid_valid); end
    tick();
    tests_run++; if (pc !== 32'h8) begin failed++; $display("FAIL seq_pc2: got %h want %h", pc, 32'h8); end
    tests_run++; if (ifid_instr !== 32'h20020003 || ifid_pc4 !== 32'h8) begin failed++;
      $display("FAIL seq_ifid2: got %h/%h want 20020003/8", ifid_instr, ifid_pc4); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    tests_run++; if (adder_enable !== 1'b0) begin failed++;
      $display("FAIL stall_adder_en: got %b want 0", adder_enable); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (pc !== 32'h8 || ifid_instr !== 32'h20020003 || ifid_pc4 !== 32'h8) begin
        failed++;
        $display("FAIL stall_hold: got pc %h instr %h pc4 %h want 8/20020003/8", pc, ifid_instr,
                 ifid_pc4);
      end
    end
    stall = 1'b0;
    tick();
    tests_run++; if (pc !== 32'hC || ifid_instr !== 32'h20000002) begin failed++;
      $display("FAIL stall_resume: got pc %h instr %h want c/20000002", pc, ifid_instr); end
  endtask

  task automatic test_redirect_priority();
    goto(32'h10);
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1; jump_target = 32'h80;
    stall = 1'b1;
    #1;
    tests_run++; if (adder_enable !== 1'b0) begin failed++;
      $display("FAIL redir_adder_en: got %b want 0", adder_enable); end
    tick();
    tests_run++; if (pc !== 32'h40) begin failed++; $display("FAIL redir_pc: got %h want %h", pc, 32'h40); end
    tests_run++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failed++;
      $display("FAIL redir_bubble: got %b/%h want 0/0", ifid_valid, ifid_instr); end
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    tick();
    tests_run++; if (pc !== 32'h44 || ifid_instr !== 32'h20000010 || ifid_pc4 !== 32'h44) begin
      failed++;
      $display("FAIL redir_target_fetch: got pc %h instr %h pc4 %h want 44/20000010/44", pc,
               ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_flush();
    goto(32'h1C);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++; if (pc !== 32'h24) begin failed++; $display("FAIL flush_pc: got %h want %h", pc, 32'h24); end
    tests_run++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failed++;
      $display("FAIL flush_bubble: got %b/%h want 0/0", ifid_valid, ifid_instr); end
  endtask

  task automatic test_halt();
    mem[3] = 32'hFC000000;
    goto(32'h8);
    tick();
    tick();
    tests_run++; if (pc !== 32'hC || halted !== 1'b1) begin failed++;
      $display("FAIL halt_enter: got pc %h halted %b want c/1", pc, halted); end
    tests_run++; if (ifid_instr !== 32'hFC000000 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h10) begin
      failed++;
      $display("FAIL halt_word: got %h/%b/%h want fc000000/1/10", ifid_instr, ifid_valid, ifid_pc4);
    end
    tests_run++; if (adder_enable !== 1'b0) begin failed++;
      $display("FAIL halt_adder_en: got %b want 0", adder_enable); end
    tick();
    tests_run++; if (pc !== 32'hC || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || halted !== 1'b1)
    begin
      failed++;
      $display("FAIL halt_drain: got pc %h valid %b instr %h halted %b want c/0/0/1", pc, ifid_valid,
               ifid_instr, halted);
    end
    goto(32'h100);
    tests_run++; if (pc !== 32'h100 || halted !== 1'b0) begin failed++;
      $display("FAIL halt_exit: got pc %h halted %b want 100/0", pc, halted); end
    mem[3] = 32'h20000003;
  endtask

  task automatic test_enable();
    tick();
    enable = 1'b0; jump = 1'b1; jump_target = 32'h200; flush = 1'b1;
    #1;
    tests_run++; if (adder_enable !== 1'b0) begin failed++;
      $display("FAIL en_adder_en: got %b want 0", adder_enable); end
    tick();
    tick();
    tests_run++; if (pc !== 32'h104 || ifid_pc4 !== 32'h104) begin failed++;
      $display("FAIL en_hold_pc: got %h/%h want 104/104", pc, ifid_pc4); end
    tests_run++; if (ifid_instr !== 32'h20000100 || ifid_valid !== 1'b1) begin failed++;
      $display("FAIL en_hold_ifid: got %h/%b want 20000100/1", ifid_instr, ifid_valid); end
    enable = 1'b1; jump = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap();
    goto(32'hFFFFFFFC);
    tick();
    tests_run++; if (pc !== 32'h0 || ifid_pc4 !== 32'h0) begin failed++;
      $display("FAIL wrap_pc: got %h/%h want 0/0", pc, ifid_pc4); end
    tests_run++; if (ifid_instr !== 32'h23FFFFFC || ifid_valid !== 1'b1) begin failed++;
      $display("FAIL wrap_instr: got %h/%b want 23fffffc/1", ifid_instr, ifid_valid); end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (pc !== 32'h0) begin failed++; $display("FAIL areset_pc: got %h want 0", pc); end
    tests_run++; if (ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0) begin
      failed++;
      $display("FAIL areset_ifid: got %b/%h/%h want 0/0/0", ifid_valid, ifid_pc4, ifid_instr);
    end
    tick();
  endtask

  function automatic logic [31:0] pick_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFFFFF8;
    if (r == 1) return $urandom;
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  task automatic test_random();
    logic [31:0] m_pc, m_pc4, m_instr, fetched;
    logic        m_valid, m_halted, m_adv;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[i][31:26] = 6'h3F;
      else if (mem[i][31:26] == 6'h3F) mem[i][31:26] = 6'h00;
    end
    rst_n = 1'b1;
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      enable        = ($urandom_range(0, 9) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_target = pick_target();
      jump_target   = pick_target();
      #1;
      m_adv = enable && !stall && !m_halted && !(branch_taken || jump);
      tests_run++; if (adder_enable !== m_adv) begin failed++;
        $display("FAIL rnd_adder_en cyc %0d: got %b want %b", cyc, adder_enable, m_adv); end
      fetched = mem_word(m_pc);
      if (enable) begin
        if (branch_taken || jump) begin
          m_pc = branch_taken ? branch_target : jump_target;
          m_pc4 = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (flush) begin
          m_pc4 = 0; m_instr = 0; m_valid = 0;
          if (!stall && !m_halted) m_pc = m_pc + 4;
        end else if (stall) begin
          // nothing moves
        end else if (m_halted) begin
          m_pc4 = 0; m_instr = 0; m_valid = 0;
        end else begin
          m_pc4 = m_pc + 4; m_instr = fetched; m_valid = 1;
          if (fetched[31:26] == 6'h3F) m_halted = 1;
          else m_pc = m_pc + 4;
        end
      end
      tick();
      tests_run++; if (pc !== m_pc) begin failed++;
        $display("FAIL rnd_pc cyc %0d: got %h want %h", cyc, pc, m_pc); end
      tests_run++; if (ifid_pc4 !== m_pc4) begin failed++;
        $display("FAIL rnd_pc4 cyc %0d: got %h want %h", cyc, ifid_pc4, m_pc4); end
      tests_run++; if (ifid_instr !== m_instr) begin failed++;
        $display("FAIL rnd_instr cyc %0d: got %h want %h", cyc, ifid_instr, m_instr); end
      tests_run++; if (ifid_valid !== m_valid) begin failed++;
        $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, ifid_valid, m_valid); end
      tests_run++; if (halted !== m_halted) begin failed++;
        $display("FAIL rnd_halted cyc %0d: got %b want %b", cyc, halted, m_halted); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h20000000 + i;
    mem[0] = 32'h20010005;
    mem[1] = 32'h20020003;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_flush();
    test_halt();
    test_enable();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
